// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
// Contents: fetch_tag_t (response tracking tag), fifo_entry_t (buffered instruction), INSTR_BYTES.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic        issued;
    logic        live;
    logic [31:0] pc;
  } fetch_tag_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fifo_entry_t;

endpackage

// File: rtl/program_memory_bus.sv
// rtl/program_memory_bus.sv - read port between a fetch requester and fixed-latency program memory
// Signals: addr, read_request (requester to memory); instr, data_valid (memory to requester).
interface program_memory_bus;
  logic [31:0] addr;
  logic        read_request;
  logic [31:0] instr;
  logic        data_valid;

  modport CONSUMER_A (output addr, output read_request, input instr, input data_valid);
  modport PROVIDER   (input addr, input read_request, output instr, output data_valid);
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer with a registered head entry
// Ports: clk_i, rst_i (sync, active-high); push_i/push_data_i write; pop_i advances head;
//        flush_i empties (wins over push and pop); count_o occupancy; head_o/head_valid_o registered head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  fifo_entry_t   push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output fifo_entry_t   head_o,
  output logic          head_valid_o
);

  localparam int PW = $clog2(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_entry_t   head_q, head_d;
  logic          head_valid_q, head_valid_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    head_d       = head_q;
    head_valid_d = head_valid_q;
    if (flush_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d      = count_q + CW'(do_push) - CW'(do_pop);
      head_valid_d = (count_d != '0);
      // The next head is the entry being written this cycle when the slot it
      // lands in is the new read slot; otherwise it is already in storage.
      if (do_push && (rd_ptr_d == wr_ptr_q)) head_d = push_data_i;
      else if (count_d != '0)                head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o      = count_q;
  assign head_o       = head_q;
  assign head_valid_o = head_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, credit-limited issue, response tags, buffer
// Ports: clk_in, rst_in (sync, active-high); mem (program memory requester side);
//        redirect_in/redirect_pc_in restart fetch; instr_out/pc_out/valid_out/ready_in to decoder;
//        protocol_err_out sticky flag for a response with no issued request.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          MEM_LATENCY = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  program_memory_bus.CONSUMER_A  mem,
  input  logic                   redirect_in,
  input  logic [31:0]            redirect_pc_in,
  output logic [31:0]            instr_out,
  output logic [31:0]            pc_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   protocol_err_out
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(MEM_LATENCY + 1);
  localparam int OW = $clog2(FIFO_DEPTH + MEM_LATENCY + 1) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  fetch_tag_t    tag_q [MEM_LATENCY];
  fetch_tag_t    tag_d [MEM_LATENCY];
  logic          err_q, err_d;
  logic [IW-1:0] inflight;
  logic [OW-1:0] occupancy;
  logic [CW-1:0] fifo_count;
  logic          read_request, pop, push;
  fetch_tag_t    tail;
  fifo_entry_t   push_entry, head;
  logic          head_valid;

  // The last tag stage lines up with the response arriving this cycle.
  assign tail       = tag_q[MEM_LATENCY-1];
  assign pop        = head_valid && ready_in && !redirect_in;
  assign push       = mem.data_valid && tail.issued && tail.live;
  assign push_entry = '{instr: mem.instr, pc: tail.pc};

  // Killed tags still hold a buffer credit until their response has come back.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) inflight = inflight + IW'(tag_q[i].issued);
  end

  // A pop this cycle frees its slot immediately, so issue resumes without a bubble.
  assign occupancy    = OW'(fifo_count) + OW'(inflight) - OW'(pop);
  assign read_request = !rst_in && !redirect_in && (occupancy < OW'(FIFO_DEPTH));

  assign mem.addr         = fetch_pc_q;
  assign mem.read_request = read_request;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_in)       fetch_pc_d = redirect_pc_in;
    else if (read_request) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
    tag_d[0] = '{issued: read_request, live: read_request, pc: fetch_pc_q};
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tag_d[i]      = tag_q[i-1];
      tag_d[i].live = tag_q[i-1].live && !redirect_in;
    end
    err_d = err_q || (mem.data_valid && !tail.issued);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_pc_q <= RESET_PC;
      err_q      <= 1'b0;
      for (int i = 0; i < MEM_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      err_q      <= err_d;
      for (int i = 0; i < MEM_LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_i        (clk_in),
    .rst_i        (rst_in),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect_in),
    .count_o      (fifo_count),
    .head_o       (head),
    .head_valid_o (head_valid)
  );

  assign instr_out        = head.instr;
  assign pc_out           = head.pc;
  assign valid_out        = head_valid;
  assign protocol_err_out = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with a 2-cycle memory model
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, redirect = 1'b0, ready = 1'b0, inject = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr_o, pc_o;
  logic        valid_o, err_o;
  int          errors = 0, checks = 0;

  program_memory_bus mem_if ();

  logic        v1, v2;
  logic [31:0] a1, a2;

  always @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      a1 <= '0;
      a2 <= '0;
    end else begin
      v1 <= mem_if.read_request;
      a1 <= mem_if.addr;
      v2 <= v1;
      a2 <= a1;
    end
  end

  assign mem_if.data_valid = v2 | inject;
  assign mem_if.instr      = inject ? 32'hDEAD_BEEF : (a2 ^ 32'hA5A5_0000);

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .FIFO_DEPTH  (4),
    .MEM_LATENCY (2)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .mem              (mem_if),
    .redirect_in      (redirect),
    .redirect_pc_in   (redirect_pc),
    .instr_out        (instr_o),
    .pc_out           (pc_o),
    .valid_out        (valid_o),
    .ready_in         (ready),
    .protocol_err_out (err_o)
  );

  task automatic do_reset;
    rst = 1'b1; redirect = 1'b0; ready = 1'b0; inject = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++; if (mem_if.read_request !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_if.read_request); end
    checks++; if (mem_if.addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_if.addr); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
  endtask

  task automatic test_stream;
    logic [31:0] exp_pc;
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) rst = 1'b0;
      #1;
      checks++; if (mem_if.read_request !== 1'b1 || mem_if.addr !== 32'(c * 4)) begin
        errors++; $display("FAIL stream_req c%0d got %b/%h want 1/%h", c, mem_if.read_request, mem_if.addr, 32'(c * 4)); end
      if (c >= 3) begin
        exp_pc = 32'((c - 3) * 4);
        checks++; if (valid_o !== 1'b1 || pc_o !== exp_pc || instr_o !== (exp_pc ^ 32'hA5A5_0000)) begin
          errors++; $display("FAIL stream_out c%0d got %b/%h/%h want 1/%h/%h", c, valid_o, pc_o, instr_o, exp_pc, exp_pc ^ 32'hA5A5_0000); end
      end else begin
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stream_early_valid c%0d got %b want 0", c, valid_o); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_pc;
    int          got;
    do_reset();
    ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) rst = 1'b0;
      #1;
      checks++; if (mem_if.read_request !== (c < 4)) begin
        errors++; $display("FAIL bp_req c%0d got %b want %b", c, mem_if.read_request, (c < 4)); end
      if (c < 4) begin
        checks++; if (mem_if.addr !== 32'(c * 4)) begin errors++; $display("FAIL bp_addr c%0d got %h want %h", c, mem_if.addr, 32'(c * 4)); end
      end
      if (c >= 3) begin
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'hA5A5_0000) begin
          errors++; $display("FAIL bp_hold c%0d got %b/%h/%h want 1/0/a5a50000", c, valid_o, pc_o, instr_o); end
      end
      @(negedge clk);
    end
    ready  = 1'b1;
    exp_pc = 32'h0;
    got    = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      #1;
      if (c == 0) begin
        checks++; if (mem_if.read_request !== 1'b1 || mem_if.addr !== 32'h10) begin
          errors++; $display("FAIL bp_resume got %b/%h want 1/00000010", mem_if.read_request, mem_if.addr); end
      end
      if (valid_o) begin
        checks++; if (pc_o !== exp_pc || instr_o !== (exp_pc ^ 32'hA5A5_0000)) begin
          errors++; $display("FAIL bp_drain got %h/%h want %h/%h", pc_o, instr_o, exp_pc, exp_pc ^ 32'hA5A5_0000); end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      @(negedge clk);
    end
    checks++; if (got != 6) begin errors++; $display("FAIL bp_drain_count got %0d want 6", got); end
  endtask

  task automatic test_redirect;
    do_reset();
    ready = 1'b1;
    redirect_pc = 32'h100;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) rst = 1'b0;
      redirect = (c == 6);
      #1;
      if (c == 6) begin
        checks++; if (mem_if.read_request !== 1'b0) begin errors++; $display("FAIL redir_noissue got %b want 0", mem_if.read_request); end
      end
      if (c == 7) begin
        checks++; if (mem_if.read_request !== 1'b1 || mem_if.addr !== 32'h100) begin
          errors++; $display("FAIL redir_req got %b/%h want 1/00000100", mem_if.read_request, mem_if.addr); end
      end
      if (c >= 7 && c <= 9) begin
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL redir_gap c%0d got %b want 0", c, valid_o); end
      end
      if (c == 10 || c == 11) begin
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'(256 + (c - 10) * 4) || instr_o !== (32'(256 + (c - 10) * 4) ^ 32'hA5A5_0000)) begin
          errors++; $display("FAIL redir_out c%0d got %b/%h/%h want 1/%h", c, valid_o, pc_o, instr_o, 32'(256 + (c - 10) * 4)); end
      end
      @(negedge clk);
    end
    redirect = 1'b0;
  endtask

  task automatic test_back_to_back_redirect;
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) rst = 1'b0;
      redirect    = (c == 5) || (c == 6);
      redirect_pc = (c == 5) ? 32'h200 : 32'h300;
      #1;
      if (c == 5 || c == 6) begin
        checks++; if (mem_if.read_request !== 1'b0) begin errors++; $display("FAIL b2b_noissue c%0d got %b want 0", c, mem_if.read_request); end
      end
      if (c == 7) begin
        checks++; if (mem_if.read_request !== 1'b1 || mem_if.addr !== 32'h300) begin
          errors++; $display("FAIL b2b_req got %b/%h want 1/00000300", mem_if.read_request, mem_if.addr); end
      end
      if (c >= 6 && c <= 9) begin
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_gap c%0d got %b want 0", c, valid_o); end
      end
      if (c == 10) begin
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h300) begin errors++; $display("FAIL b2b_out got %b/%h want 1/00000300", valid_o, pc_o); end
      end
      @(negedge clk);
    end
    redirect = 1'b0;
  endtask

  task automatic test_redirect_pop;
    logic seen;
    seen = 1'b0;
    do_reset();
    ready = 1'b1;
    redirect_pc = 32'h400;
    for (int c = 0; c < 14; c++) begin
      if (c == 0) rst = 1'b0;
      redirect = (c == 5);
      #1;
      if (c == 5) begin
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h8) begin errors++; $display("FAIL rpop_head got %b/%h want 1/00000008", valid_o, pc_o); end
      end
      if (c > 5 && valid_o && !seen) begin
        seen = 1'b1;
        checks++; if (pc_o !== 32'h400 || c != 9) begin errors++; $display("FAIL rpop_next got %h at c%0d want 00000400 at c9", pc_o, c); end
      end
      @(negedge clk);
    end
    redirect = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL rpop_timeout got no valid want 00000400"); end
  endtask

  task automatic test_protocol_err;
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) rst = 1'b0;
      inject = (c == 0);
      #1;
      if (c == 0) begin
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL perr_before got %b want 0", err_o); end
      end
      if (c == 1 || c == 10) begin
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL perr_sticky c%0d got %b want 1", c, err_o); end
      end
      if (c == 1 || c == 2) begin
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL perr_nopush c%0d got %b want 0", c, valid_o); end
      end
      if (c == 3) begin
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'hA5A5_0000) begin
          errors++; $display("FAIL perr_stream got %b/%h/%h want 1/0/a5a50000", valid_o, pc_o, instr_o); end
      end
      @(negedge clk);
    end
    inject = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (err_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL perr_clear got %b/%b want 0/0", err_o, valid_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back_redirect();
    test_redirect_pop();
    test_protocol_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
